// File: rtl/hazard_ctrl.sv
// Stall and operand-bypass controller for the five-stage pipeline.
// Tracks in-flight writes in E/M/W and resolves read hazards for D, E and M.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_we,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m
);

  typedef struct packed {
    logic       we;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } rec_t;

  rec_t e_q, m_q, w_q;
  rec_t e_d, m_d, w_d;

  // A stage record only matches a real register it actually writes.
  function automatic logic live(input rec_t r, input logic [4:0] idx);
    return r.we && (r.a3 == idx) && (idx != 5'd0);
  endfunction

  function automatic logic needs_stall(input rec_t e, input rec_t m,
                                       input logic [4:0] idx, input logic [1:0] tuse);
    return (tuse != 2'd3) &&
           ((live(e, idx) && (e.tnew > tuse)) || (live(m, idx) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] sel_d(input rec_t e, input rec_t m, input rec_t w,
                                       input logic [4:0] idx);
    if (live(e, idx) && (e.tnew == 2'd0))      return 2'd1;
    else if (live(m, idx) && (m.tnew == 2'd0)) return 2'd2;
    else if (live(w, idx) && (w.tnew == 2'd0)) return 2'd3;
    else                                       return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(input rec_t m, input rec_t w, input logic [4:0] idx);
    if (live(m, idx) && (m.tnew == 2'd0))      return 2'd2;
    else if (live(w, idx) && (w.tnew == 2'd0)) return 2'd3;
    else                                       return 2'd0;
  endfunction

  always_comb begin
    stall    = needs_stall(e_q, m_q, d_rs, d_tuse_rs) | needs_stall(e_q, m_q, d_rt, d_tuse_rt);
    fwd_rs_d = sel_d(e_q, m_q, w_q, d_rs);
    fwd_rt_d = sel_d(e_q, m_q, w_q, d_rt);
    fwd_rs_e = sel_e(m_q, w_q, e_q.rs);
    fwd_rt_e = sel_e(m_q, w_q, e_q.rt);
    fwd_rt_m = live(w_q, m_q.rt);
  end

  // Records advance every cycle; a stalled D instruction is replaced by a bubble in E.
  always_comb begin
    w_d      = m_q;
    w_d.tnew = 2'd0;
    m_d      = e_q;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    e_d      = '0;
    if (!stall) begin
      e_d.we   = d_we;
      e_d.a3   = d_a3;
      e_d.tnew = d_tnew;
      e_d.rs   = d_rs;
      e_d.rt   = d_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Source indices beyond the stage that consumes them are carried but never compared.
  logic unused_fields;
  assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt};

endmodule
